// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
//
// Holds the fetch PC and issues in-order requests to instruction memory. It
// buffers the returned instructions with their PCs and presents the oldest
// {PC, instr} pair to IF/ID. A redirect from MEM reloads the fetch PC, flushes
// everything fetched so far and drops responses to requests already in flight.
//
// Ports:
//   clk, resetN                  clock (rising edge), async active-low reset
//   stall                        hold the IF/ID input; buffer head not consumed
//   redirect, redirectAddr       taken branch/jump from MEM and its target
//   imemReqValid/Ready/Addr      request channel (valid/ready)
//   imemRespValid/Instr          response channel (valid only, in order)
//   PCOut, instrOut              {PC, instr} to IF/ID
//   IFIDFlush                    flush to IF/ID
module fetch_unit #(
  parameter int                    ADDR_SIZE  = 32,
  parameter int                    INSTR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_SIZE-1:0]  redirectAddr,
  output logic                  imemReqValid,
  output logic [ADDR_SIZE-1:0]  imemReqAddr,
  input  logic                  imemReqReady,
  input  logic                  imemRespValid,
  input  logic [INSTR_SIZE-1:0] imemRespInstr,
  output logic [ADDR_SIZE-1:0]  PCOut,
  output logic [INSTR_SIZE-1:0] instrOut,
  output logic                  IFIDFlush
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]        CAP = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(32'h0000_0013);

  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } fetchEntry_t;

  logic [ADDR_SIZE-1:0] fetchPC;
  logic [ADDR_SIZE-1:0] pendPC [BUF_DEPTH];
  fetchEntry_t          instrBuf [BUF_DEPTH];
  logic [PTR_W-1:0]     pendRd, pendWr, bufRd, bufWr;
  logic [CNT_W-1:0]     bufCount, outstanding, dropCnt;

  logic           reqAccept, respKeep, respDrop, bufPop;
  logic [CNT_W:0] inFlight;

  // Issue looks at occupancy before this cycle's pop, so buffered plus
  // outstanding never exceeds BUF_DEPTH; a landing response always has room.
  assign inFlight     = {1'b0, bufCount} + {1'b0, outstanding};
  assign imemReqValid = resetN && !redirect && (inFlight < CAP);
  assign imemReqAddr  = fetchPC;
  assign reqAccept    = imemReqValid && imemReqReady;

  // Responses owed to requests issued before a redirect are dropped first.
  assign respDrop = imemRespValid && (dropCnt != '0);
  assign respKeep = imemRespValid && (dropCnt == '0) && !redirect;
  assign bufPop   = !stall && (bufCount != '0) && !redirect;

  assign IFIDFlush = redirect && resetN;
  assign PCOut     = (bufCount != '0) ? instrBuf[bufRd].pc    : '0;
  assign instrOut  = (bufCount != '0) ? instrBuf[bufRd].instr : NOP;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetchPC     <= RESET_PC;
      pendRd      <= '0;
      pendWr      <= '0;
      bufRd       <= '0;
      bufWr       <= '0;
      bufCount    <= '0;
      outstanding <= '0;
      dropCnt     <= '0;
    end else if (redirect) begin
      fetchPC     <= redirectAddr;
      pendRd      <= '0;
      pendWr      <= '0;
      bufRd       <= '0;
      bufWr       <= '0;
      bufCount    <= '0;
      // Everything still outstanding after this edge is now stale.
      outstanding <= outstanding - CNT_W'(imemRespValid);
      dropCnt     <= outstanding - CNT_W'(imemRespValid);
    end else begin
      if (reqAccept) begin
        fetchPC <= fetchPC + ADDR_SIZE'(4);
        pendWr  <= pendWr + PTR_W'(1);
      end
      if (respKeep) begin
        pendRd <= pendRd + PTR_W'(1);
        bufWr  <= bufWr + PTR_W'(1);
      end
      if (respDrop) dropCnt <= dropCnt - CNT_W'(1);
      if (bufPop)   bufRd   <= bufRd + PTR_W'(1);
      bufCount    <= bufCount + CNT_W'(respKeep) - CNT_W'(bufPop);
      outstanding <= outstanding + CNT_W'(reqAccept) - CNT_W'(imemRespValid);
    end
  end

  // Storage arrays carry no reset; the pointers/counts above define validity.
  always_ff @(posedge clk) begin
    if (reqAccept) pendPC[pendWr] <= fetchPC;
    if (respKeep)  instrBuf[bufWr] <= '{pc: pendPC[pendRd], instr: imemRespInstr};
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetN, stall, redirect;
  logic [31:0] redirectAddr;
  logic        imemReqValid, imemReqReady, imemRespValid;
  logic [31:0] imemReqAddr, imemRespInstr, PCOut, instrOut;
  logic        IFIDFlush;

  fetch_unit #(.ADDR_SIZE(32), .INSTR_SIZE(32), .RESET_PC(32'h0), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .resetN(resetN), .stall(stall), .redirect(redirect),
    .redirectAddr(redirectAddr), .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr),
    .imemReqReady(imemReqReady), .imemRespValid(imemRespValid), .imemRespInstr(imemRespInstr),
    .PCOut(PCOut), .instrOut(instrOut), .IFIDFlush(IFIDFlush)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } memReq_t;
  memReq_t respQ[$];

  int nCmp = 0, nFail = 0;
  int cyc = 0, lat = 1;
  bit sbOn = 0;
  logic [31:0] expNext;
  logic        obsValid, obsFlush;
  logic [31:0] obsAddr, obsPC, obsInstr;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic bit respDue();
    return (respQ.size() > 0) && (respQ[0].due <= cyc + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge. Acts as the
  // instruction memory (fixed latency 'lat') and, when sbOn, as the
  // in-order delivery scoreboard.
  task automatic step();
    bit acc;
    logic [31:0] accAddr;
    if (resetN && respDue()) begin
      imemRespValid = 1'b1;
      imemRespInstr = instrOf(respQ[0].addr);
      void'(respQ.pop_front());
    end else begin
      imemRespValid = 1'b0;
      imemRespInstr = 32'h0;
    end
    #1;
    obsValid = imemReqValid; obsAddr = imemReqAddr; obsPC = PCOut;
    obsInstr = instrOut;     obsFlush = IFIDFlush;
    acc = imemReqValid && imemReqReady;
    accAddr = imemReqAddr;
    if (sbOn && resetN) begin
      if (redirect) begin
        chk("sb flush", {31'b0, obsFlush}, 32'd1);
        chk("sb noreq", {31'b0, obsValid}, 32'd0);
        expNext = redirectAddr;
      end else begin
        chk("sb flush", {31'b0, obsFlush}, 32'd0);
        if (obsInstr !== NOP) begin
          chk("sb pc", obsPC, expNext);
          chk("sb instr", obsInstr, instrOf(expNext));
          if (!stall) expNext = expNext + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (acc) respQ.push_back('{addr: accAddr, due: cyc + lat});
    if (sbOn) chk("cap", {31'b0, respQ.size() <= BUF_DEPTH}, 32'd1);
    @(negedge clk);
  endtask

  // Hand-derived first cycles after reset release (latency 1, ready, no stall).
  logic [31:0] t1Addr [7] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h10, 32'h10};
  logic        t1V    [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] t1PC   [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'hC};
  logic        t1Nop  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [31:0] heldPC;
    resetN = 1'b0; stall = 1'b0; redirect = 1'b1; redirectAddr = 32'h0;
    imemReqReady = 1'b1; imemRespValid = 1'b0; imemRespInstr = 32'h0;
    #2;
    chk("rst reqValid", {31'b0, imemReqValid}, 32'd0);
    chk("rst flush", {31'b0, IFIDFlush}, 32'd0);
    chk("rst pc", PCOut, 32'h0);
    chk("rst instr", instrOut, NOP);
    @(negedge clk);
    redirect = 1'b0;
    resetN = 1'b1;

    // 1: startup stream
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t1 reqValid", {31'b0, obsValid}, {31'b0, t1V[i]});
      chk("t1 reqAddr", obsAddr, t1Addr[i]);
      chk("t1 pc", obsPC, t1PC[i]);
      chk("t1 instr", obsInstr, t1Nop[i] ? NOP : instrOf(t1PC[i]));
      chk("t1 flush", {31'b0, obsFlush}, 32'd0);
    end
    expNext = 32'h10;
    sbOn = 1;

    // 2: three-cycle stall mid-stream
    step(); step();
    stall = 1'b1;
    step(); heldPC = obsPC;
    step(); step();
    chk("t2 held", obsPC, heldPC);
    stall = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("t2 progress", {31'b0, expNext >= 32'h20}, 32'd1);

    // 3: redirect with two requests outstanding (latency 3)
    lat = 3;
    for (int i = 0; i < 20 && respQ.size() != 2; i++) step();
    chk("t3 two outstanding", respQ.size(), 32'd2);
    redirect = 1'b1; redirectAddr = 32'h100;
    step();
    chk("t3 flush", {31'b0, obsFlush}, 32'd1);
    redirect = 1'b0;
    step();
    chk("t3 flush off", {31'b0, obsFlush}, 32'd0);
    chk("t3 target", obsAddr, 32'h100);
    for (int i = 0; i < 20; i++) step();
    chk("t3 progress", {31'b0, expNext >= 32'h108}, 32'd1);

    // 4: redirect while stalled with a full buffer
    lat = 1;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t4 issue stopped", {31'b0, obsValid}, 32'd0);
    redirect = 1'b1; redirectAddr = 32'h200;
    step();
    redirect = 1'b0;
    step();
    chk("t4 cleared pc", obsPC, 32'h0);
    chk("t4 cleared instr", obsInstr, NOP);
    chk("t4 req 200", obsAddr, 32'h200);
    chk("t4 req valid", {31'b0, obsValid}, 32'd1);
    step();
    chk("t4 still nop", obsInstr, NOP);
    step();
    chk("t4 head pc", obsPC, 32'h200);
    chk("t4 head instr", obsInstr, instrOf(32'h200));
    stall = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t4 progress", {31'b0, expNext >= 32'h208}, 32'd1);

    // 5: ready toggling, latency 3
    lat = 3;
    for (int i = 0; i < 40; i++) begin
      imemReqReady = (i % 2 == 0);
      step();
    end
    imemReqReady = 1'b1;
    chk("t5 progress", {31'b0, expNext >= 32'h218}, 32'd1);

    // 6: reset pulse while one stale response is owed
    for (int i = 0; i < 30 &&
         !((respQ.size() == 2 && respDue()) || (respQ.size() == 1 && !respDue())); i++)
      step();
    chk("t6 setup", {31'b0, (respQ.size() == 2 && respDue()) || (respQ.size() == 1 && !respDue())}, 32'd1);
    redirect = 1'b1; redirectAddr = 32'h300;
    step();
    redirect = 1'b0;
    resetN = 1'b0;
    redirect = 1'b1;
    #1;
    chk("t6 rst reqValid", {31'b0, imemReqValid}, 32'd0);
    chk("t6 rst flush", {31'b0, IFIDFlush}, 32'd0);
    chk("t6 rst pc", PCOut, 32'h0);
    chk("t6 rst instr", instrOut, NOP);
    respQ.delete();
    step();
    redirect = 1'b0;
    resetN = 1'b1;
    lat = 1;
    expNext = 32'h0;
    step();
    chk("t6 restart addr", obsAddr, 32'h0);
    chk("t6 restart valid", {31'b0, obsValid}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("t6 progress", {31'b0, expNext >= 32'h8}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
